// File: rtl/gf8_pkg.sv
// gf8_pkg: shared types and constants for the GF(2^8) reduction blocks.
//   state_t       - sequencer FSM states
//   GF8_POLY_AES  - default reduction polynomial x^8+x^4+x^3+x+1
//   PROD_W/ELEM_W - carry-less product width / field element width
package gf8_pkg;
  localparam int PROD_W = 15;
  localparam int ELEM_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [ELEM_W:0]  GF8_POLY_AES = 9'h11B;
  // Highest reducible bit is 14 = 8 + 6, so the walk starts at cnt=6.
  localparam logic [CNT_W-1:0] CNT_TOP      = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/gf8_reduce_step.sv
// gf8_reduce_step: one combinational reduction step.
//   r      in  - partial remainder (15 bits)
//   cnt    in  - bit position being cleared is 8+cnt
//   r_next out - r ^ (POLY << cnt) when bit 8+cnt is set, else r
// POLY must have bit 8 set so that the XOR clears bit 8+cnt.
module gf8_reduce_step
  import gf8_pkg::*;
#(
  parameter logic [ELEM_W:0] POLY = GF8_POLY_AES
) (
  input  logic [PROD_W-1:0] r,
  input  logic [CNT_W-1:0]  cnt,
  output logic [PROD_W-1:0] r_next
);
  logic [PROD_W-1:0] poly_sh;
  logic [PROD_W-1:0] r_sh;

  assign poly_sh = {{(PROD_W-ELEM_W-1){1'b0}}, POLY} << cnt;
  // Shift instead of indexing r[8+cnt] so no index can leave the vector.
  assign r_sh    = r >> cnt;
  assign r_next  = r_sh[ELEM_W] ? (r ^ poly_sh) : r;
endmodule

// File: rtl/gf8_reduce_seq.sv
// gf8_reduce_seq: sequential GF(2^8) reduction of a 15-bit carry-less
// product, one bit position per cycle, fixed 7-cycle latency.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - product input handshake, in_prod[14:0]
//   out_valid/out_ready  - result handshake, out_elem[7:0]
//   busy                 - high while reducing
// Optional build macro GF8_REDUCE_ACC_EN adds acc_clr and an 8-bit
// XOR accumulator: out_elem = acc ^ remainder, acc <= out_elem on each
// output handshake, acc_clr zeroes acc with priority.
module gf8_reduce_seq
  import gf8_pkg::*;
#(
  parameter logic [ELEM_W:0] POLY = GF8_POLY_AES
) (
  input  logic              clk,
  input  logic              rst,
`ifdef GF8_REDUCE_ACC_EN
  input  logic              acc_clr,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_elem,
  output logic              busy
);
  state_t             state;
  logic [PROD_W-1:0]  r;
  logic [PROD_W-1:0]  r_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  gf8_reduce_step #(.POLY(POLY)) u_step (
    .r      (r),
    .cnt    (cnt),
    .r_next (r_next)
  );

  // A held result frees the input slot on the same edge it is taken,
  // which is what allows back-to-back products with no bubble.
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            r         <= in_prod;
            cnt       <= CNT_TOP;
            state     <= REDUCE;
            busy      <= 1'b1;
            out_valid <= 1'b0;
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        REDUCE: begin
          r <= r_next;
          // Always walk all 7 positions: latency never depends on data.
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef GF8_REDUCE_ACC_EN
  logic [ELEM_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst || acc_clr)
      acc <= '0;
    else if (state == DONE && out_ready)
      acc <= out_elem;
  end

  assign out_elem = (state == DONE) ? (acc ^ r[ELEM_W-1:0]) : r[ELEM_W-1:0];
`else
  assign out_elem = r[ELEM_W-1:0];
`endif
endmodule

// File: tb/tb_gf8_reduce_seq.sv
// tb_gf8_reduce_seq: directed + random bench for gf8_reduce_seq.
// Reference result is sum over set product bits of x^i mod POLY, with
// x^i built by repeated xtime. Honours GF8_REDUCE_ACC_EN when defined.
module tb_gf8_reduce_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [14:0] in_prod;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_elem;
  logic        busy;
`ifdef GF8_REDUCE_ACC_EN
  logic        acc_clr;
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] acc_m;
  logic [7:0] got;
  logic [7:0] pre;
  logic [7:0] expv;
  logic [7:0] exp2;
  int         lat;
  int         nval;

  always #5 clk = ~clk;

  gf8_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
`ifdef GF8_REDUCE_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elem  (out_elem),
    .busy      (busy)
  );

  function automatic logic [7:0] gf_ref(input logic [14:0] p);
    logic [8:0] pw;
    logic [7:0] s;
    s  = 8'h00;
    pw = 9'h001;
    for (int i = 0; i < 15; i++) begin
      if (p[i]) s ^= pw[7:0];
      pw = pw << 1;
      if (pw[8]) pw ^= 9'h11B;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Called one #1 after an edge; consumes the accept edge.
  task automatic accept(input logic [14:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_prod  = 15'($urandom);
  endtask

  // Counts edges after accept until out_valid; optionally scribbles on
  // the input side meanwhile.
  task automatic wait_out(input bit tog, output int n);
    n = 0;
    while (n < 20) begin
      if (tog) begin
        in_valid = 1'($urandom);
        in_prod  = 15'($urandom);
      end
      @(posedge clk);
      n++;
      #1;
      if (out_valid === 1'b1) break;
    end
    in_valid = 1'b0;
  endtask

  // Full transaction with out_ready=1: accept, wait, check, drain.
  task automatic run(input string tag, input logic [14:0] p, input bit tog,
                     output logic [7:0] o, output logic [7:0] a);
    int n;
    logic [7:0] e;
    a = acc_m;
    e = acc_m ^ gf_ref(p);
    chk({tag, "_rdy"}, in_ready, 1);
    accept(p);
    chk({tag, "_busy"}, busy, 1);
    wait_out(tog, n);
    chk({tag, "_lat"}, n, 7);
    chk({tag, "_elem"}, out_elem, e);
    o = out_elem;
    @(posedge clk);
    #1;
    if (ACC) acc_m = e;
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    acc_m     = 8'h00;
`ifdef GF8_REDUCE_ACC_EN
    acc_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_irdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_elem", out_elem, 8'h00);

    // reset beats a simultaneous accept
    in_valid = 1'b1;
    in_prod  = 15'h2B79;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rstpri_busy", busy, 0);
    chk("rstpri_irdy", in_ready, 1);

    // directed products
    run("aes", 15'h2B79, 1'b0, got, pre);
    chk("aes_c1", got ^ pre, 8'hC1);
    run("x14", 15'h4000, 1'b0, got, pre);
    chk("x14_9a", got ^ pre, 8'h9A);
    run("x8", 15'h0100, 1'b0, got, pre);
    chk("x8_1b", got ^ pre, 8'h1B);
    run("ff", 15'h00FF, 1'b0, got, pre);
    chk("ff_ff", got ^ pre, 8'hFF);

    // backpressure, then release with a back-to-back accept
    out_ready = 1'b0;
    expv = acc_m ^ gf_ref(15'h2B79);
    accept(15'h2B79);
    wait_out(1'b0, lat);
    chk("bp_lat", lat, 7);
    chk("bp_elem", out_elem, expv);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_e", out_elem, expv);
      chk("bp_hold_r", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", in_ready, 1);
    accept(15'h4000);
    if (ACC) acc_m = expv;
    exp2 = acc_m ^ gf_ref(15'h4000);
    chk("b2b_busy", busy, 1);
    chk("b2b_ov", out_valid, 0);
    wait_out(1'b0, lat);
    chk("b2b_lat", lat, 7);
    chk("b2b_elem", out_elem, exp2);
    @(posedge clk);
    #1;
    if (ACC) acc_m = exp2;

    // input noise while reducing
    run("tog", 15'($urandom), 1'b1, got, pre);
    run("tog2", 15'h7FFF, 1'b1, got, pre);

    // reset three edges after accept drops the product
    accept(15'($urandom));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    acc_m = 8'h00;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_elem", out_elem, 8'h00);
    nval = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) nval++;
    end
    chk("mid_rst_stale", nval, 0);

    // random products
    for (int i = 0; i < 20; i++) run("rnd", 15'($urandom), 1'b0, got, pre);

`ifdef GF8_REDUCE_ACC_EN
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    acc_m   = 8'h00;
    run("acc1", 15'h2B79, 1'b0, got, pre);
    chk("acc1_c1", got, 8'hC1);
    run("acc2", 15'h0100, 1'b0, got, pre);
    chk("acc2_da", got, 8'hDA);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    acc_m   = 8'h00;
    run("acc3", 15'h00FF, 1'b0, got, pre);
    chk("acc3_ff", got, 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gf8_reduce_seq.md
GF8_REDUCE_SEQ -- requirements
Module: gf8_reduce_seq

Interface
REQ-001 SHALL have parameter POLY, default 9'h11B, the GF(2^8) reduction polynomial; bit 8 must be 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_prod is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a product.
REQ-006 SHALL have port in_prod, input, 15 bits: carry-less 8x8 product from the upstream GF(2) multiplier.
REQ-007 SHALL have port out_valid, output, 1 bit: out_elem is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_elem.
REQ-009 SHALL have port out_elem, output, 8 bits: the reduced field element.
REQ-010 SHALL have port busy, output, 1 bit: high when the state is REDUCE.

Function
REQ-011 SHALL implement the FSM states IDLE, REDUCE and DONE.
REQ-012 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-013 SHALL, on an accept edge (in_valid && in_ready): load r[14:0] = in_prod, set cnt = 6, and enter REDUCE.
REQ-014 SHALL, on each REDUCE edge: if r[8+cnt]==1, set r = r ^ (POLY << cnt); then decrement cnt.
REQ-015 SHALL move to DONE on the REDUCE edge where cnt==0; no edge ever processes an index below 0.
REQ-016 SHALL have a fixed latency: out_valid rises 7 edges after the accept edge, for every value of in_prod (no early exit).
REQ-017 SHALL drive, in DONE: out_valid=1 and out_elem=r[7:0]; r[14:8] is then zero.
REQ-018 SHALL hold out_elem and out_valid stable in DONE while out_ready=0.
REQ-019 SHALL, on a DONE edge with out_ready=1 and in_valid=0, go to IDLE with out_valid=0.
REQ-020 SHALL, on a DONE edge with out_ready=1 and in_valid=1, apply REQ-013 (back-to-back) with no idle bubble.
REQ-021 SHALL ignore in_valid and in_prod during REDUCE (in_ready=0).
REQ-022 SHALL drive out_valid=0 in IDLE and REDUCE; out_elem is then don't-care but is driven from r[7:0].

Reset
REQ-023 SHALL, on rst: set state=IDLE, r=0, cnt=0, out_valid=0, out_elem=0, busy=0, in_ready=1 (the next cycle).
REQ-024 SHALL, on rst mid-REDUCE or mid-DONE, discard the in-flight product with no output handshake.
REQ-025 SHALL give rst priority over a simultaneous accept or output handshake.

Configuration
REQ-026 SHALL support the macro GF8_REDUCE_ACC_EN.
- Defined: add input acc_clr (1 bit) and an 8-bit accumulator acc.
- out_elem = acc ^ r[7:0] in DONE.
- On the output handshake, acc takes the value of out_elem.
- acc_clr=1 on any edge sets acc=0, with priority over the handshake update.
- rst clears acc.
REQ-027 SHALL, when GF8_REDUCE_ACC_EN is undefined, have no acc_clr port and no acc register, and behave exactly per REQ-017.

Structure
REQ-028 SHALL take from the shared package gf8_pkg: the state enum, the default polynomial constant GF8_POLY_AES = 9'h11B, and the width constants (PROD_W=15, ELEM_W=8).
REQ-029 SHALL place the single-step conditional XOR (r, cnt, POLY -> r_next) in one combinational sub-module, gf8_reduce_step; the FSM, counter and handshake logic stay in gf8_reduce_seq.

Verification
REQ-030 SHALL cover: in_prod=15'h2B79 (0x57 x 0x83), out_ready=1 -> out_valid exactly 7 edges after accept, out_elem=8'hC1.
REQ-031 SHALL cover: in_prod=15'h4000 -> 8'h9A; in_prod=15'h0100 -> 8'h1B; in_prod=15'h00FF -> 8'hFF (same 7-cycle latency each).
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_elem/out_valid stable and in_ready=0; release with in_valid=1 -> new accept on the same edge, next result 7 edges later.
REQ-033 SHALL cover: rst asserted 3 edges after an accept -> next cycle state IDLE, out_valid=0, in_ready=1; no stale output ever appears.
REQ-034 SHALL cover: in_valid toggled during REDUCE with differing in_prod values -> no effect on the result in flight.
REQ-035 SHALL cover (GF8_REDUCE_ACC_EN): acc_clr pulse, then products 15'h2B79 and 15'h0100 -> outputs 8'hC1, then 8'hDA (C1^1B); acc_clr pulse -> next output is unaccumulated.
